// File: rtl/matrix_arb_pkg.sv
// Shared constants for the bus-matrix output-port arbiter: default port count,
// port-index width helper and the AHB HTRANS encodings.
package matrix_arb_pkg;

    localparam int NUM_PORTS_DEF = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    // Index width for n ports; never below one bit.
    function automatic int port_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/matrix_output_arb_rr_pick.sv
// Rotate-priority find-first: the first requester strictly after ptr,
// wrapping modulo NUM_PORTS, wins; none flags an empty request vector.
module rr_pick
    import matrix_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = port_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    winner,
    output logic                 none
);

    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        none   = 1'b1;
        // Farthest offset first so the nearest requester after ptr overwrites last.
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                winner = PORT_W'(idx);
                none   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_output_arb.sv
// Round-robin owner arbiter for one bus-matrix output port with burst hold and,
// when MATRIX_ARB_LOCK_EN is defined, locked-sequence hold.
module matrix_output_arb
    import matrix_arb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = port_w(NUM_PORTS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_PORTS-1:0]   req_op,
    input  logic [2*NUM_PORTS-1:0] trans_op,
    input  logic [NUM_PORTS-1:0]   lock_op,
    input  logic                   HREADYM,
    output logic [PORT_W-1:0]      addr_in_port,
    output logic                   no_port,
    output logic [PORT_W-1:0]      data_in_port,
    output logic [NUM_PORTS-1:0]   active_op,
    output logic                   sel_out
);

    logic [PORT_W-1:0] owner;
    logic              no_port_q;
    logic [PORT_W-1:0] data_port;
    logic [PORT_W-1:0] rr_ptr;

    logic [PORT_W-1:0] owner_nxt;
    logic              no_port_nxt;
    logic [PORT_W-1:0] rr_ptr_nxt;

    logic [PORT_W-1:0] rr_winner;
    logic              rr_none;
    logic [1:0]        owner_trans;
    logic              owner_req;
    logic              burst_hold;
    logic              lock_hold;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req    (req_op),
        .ptr    (rr_ptr),
        .winner (rr_winner),
        .none   (rr_none)
    );

    // Hold terms only apply to a real owner; a parked index owns nothing.
    assign owner_trans = trans_op[2*int'(owner) +: 2];
    assign owner_req   = req_op[owner] & ~no_port_q;
    assign burst_hold  = owner_req &
                         ((owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY));

`ifdef MATRIX_ARB_LOCK_EN
    assign lock_hold = owner_req & lock_op[owner];
`else
    logic unused_lock;
    assign unused_lock = ^lock_op;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        owner_nxt   = owner;
        no_port_nxt = no_port_q;
        rr_ptr_nxt  = rr_ptr;
        if (burst_hold || lock_hold) begin
            no_port_nxt = 1'b0;
        end else if (!rr_none) begin
            owner_nxt   = rr_winner;
            rr_ptr_nxt  = rr_winner;
            no_port_nxt = 1'b0;
        end else begin
            no_port_nxt = 1'b1;
        end
    end

    // Address-phase owner registers; data phase trails by one ready edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner     <= '0;
            no_port_q <= 1'b1;
            data_port <= '0;
            rr_ptr    <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            owner     <= owner_nxt;
            no_port_q <= no_port_nxt;
            rr_ptr    <= rr_ptr_nxt;
            if (!no_port_q) begin
                data_port <= owner;
            end
        end
    end

    assign addr_in_port = owner;
    assign no_port      = no_port_q;
    assign data_in_port = data_port;
    assign sel_out      = ~no_port_q;

    always_comb begin
        active_op = '0;
        if (!no_port_q) begin
            active_op[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_output_arb.sv
// Self-checking bench for matrix_output_arb: directed scenarios plus random
// traffic against a distance-based round-robin reference model.
module tb_matrix_output_arb;
    import matrix_arb_pkg::*;

    localparam int N  = 3;
    localparam int PW = port_w(N);

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic           HREADYM;
    logic [N-1:0]   req_op;
    logic [2*N-1:0] trans_op;
    logic [N-1:0]   lock_op;
    logic [PW-1:0]  addr_in_port;
    logic           no_port;
    logic [PW-1:0]  data_in_port;
    logic [N-1:0]   active_op;
    logic           sel_out;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner;
    int m_last;
    int m_data;
    bit m_none;

    always #5 HCLK = ~HCLK;

    matrix_output_arb #(.NUM_PORTS(N)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_op       (req_op),
        .trans_op     (trans_op),
        .lock_op      (lock_op),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .data_in_port (data_in_port),
        .active_op    (active_op),
        .sel_out      (sel_out)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_trans(input int p, input logic [1:0] t);
        trans_op[2*p +: 2] = t;
    endtask

    // Reference: nearest requester by circular distance after the last grant.
    task automatic model_edge();
        int  best;
        int  bestd;
        int  d;
        bit  hold;
        logic [1:0] t;
        if (!HRESETn) begin
            m_owner = 0;
            m_none  = 1'b1;
            m_data  = 0;
            m_last  = N - 1;
        end else if (HREADYM) begin
            t    = trans_op[2*m_owner +: 2];
            hold = !m_none && req_op[m_owner] && (t == 2'b11 || t == 2'b01);
`ifdef MATRIX_ARB_LOCK_EN
            if (!m_none && req_op[m_owner] && lock_op[m_owner]) hold = 1'b1;
`endif
            if (!m_none) m_data = m_owner;
            if (!hold) begin
                best  = -1;
                bestd = N;
                for (int p = 0; p < N; p++) begin
                    d = (p - m_last - 1 + 2*N) % N;
                    if (req_op[p] && d < bestd) begin
                        bestd = d;
                        best  = p;
                    end
                end
                if (best >= 0) begin
                    m_owner = best;
                    m_last  = best;
                    m_none  = 1'b0;
                end else begin
                    m_none = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge HCLK);
        #1;
        check_val("addr_in_port", int'(addr_in_port), m_owner);
        check_val("no_port", int'(no_port), int'(m_none));
        check_val("data_in_port", int'(data_in_port), m_data);
        check_val("sel_out", int'(sel_out), int'(!m_none));
        check_val("active_op", int'(active_op), m_none ? 0 : (1 << m_owner));
    endtask

    initial begin
        int a_hold;
        int d_hold;
        HRESETn  = 1'b0;
        HREADYM  = 1'b1;
        req_op   = '0;
        trans_op = '0;
        lock_op  = '0;
        step();
        step();
        HRESETn = 1'b1;
        step();
        check_val("reset_no_port", int'(no_port), 1);
        check_val("reset_sel", int'(sel_out), 0);
        check_val("reset_addr", int'(addr_in_port), 0);
        check_val("reset_active", int'(active_op), 0);

        // Single requester on port 2.
        req_op = 3'b100;
        set_trans(2, HTRANS_NONSEQ);
        step();
        check_val("single_addr", int'(addr_in_port), 2);
        check_val("single_active", int'(active_op), 4);
        req_op = 3'b000;
        set_trans(2, HTRANS_IDLE);
        step();
        check_val("single_data", int'(data_in_port), 2);

        // All ports NONSEQ: rotation 0,1,2,0.
        req_op   = 3'b111;
        trans_op = 6'b101010;
        step(); check_val("rr_0", int'(addr_in_port), 0);
        step(); check_val("rr_1", int'(addr_in_port), 1);
        step(); check_val("rr_2", int'(addr_in_port), 2);
        step(); check_val("rr_3", int'(addr_in_port), 0);

        // Port 1 burst NONSEQ + 3xSEQ while port 0 waits.
        req_op   = 3'b011;
        trans_op = '0;
        set_trans(0, HTRANS_NONSEQ);
        set_trans(1, HTRANS_NONSEQ);
        step(); check_val("burst_e1", int'(addr_in_port), 1);
        set_trans(1, HTRANS_SEQ);
        step(); check_val("burst_e2", int'(addr_in_port), 1);
        step(); check_val("burst_e3", int'(addr_in_port), 1);
        step(); check_val("burst_e4", int'(addr_in_port), 1);
        req_op = 3'b001;
        set_trans(1, HTRANS_IDLE);
        step(); check_val("burst_e5", int'(addr_in_port), 0);

        // Stall for 3 cycles with changing requests.
        a_hold  = int'(addr_in_port);
        d_hold  = int'(data_in_port);
        HREADYM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_op = 3'(1 << k);
            step();
            check_val("stall_addr", int'(addr_in_port), a_hold);
            check_val("stall_data", int'(data_in_port), d_hold);
        end
        HREADYM = 1'b1;
        req_op  = 3'b110;
        trans_op = 6'b101000;
        step();
        check_val("stall_release_addr", int'(addr_in_port), 1);
        check_val("stall_release_data", int'(data_in_port), 0);

        // Port 2 locked NONSEQ, IDLE, NONSEQ while port 0 requests.
        req_op   = 3'b100;
        lock_op  = 3'b100;
        trans_op = '0;
        set_trans(2, HTRANS_NONSEQ);
        step(); check_val("lock_grant", int'(addr_in_port), 2);
        req_op = 3'b101;
        set_trans(0, HTRANS_NONSEQ);
        set_trans(2, HTRANS_IDLE);
        step();
`ifdef MATRIX_ARB_LOCK_EN
        check_val("lock_idle", int'(addr_in_port), 2);
        set_trans(2, HTRANS_NONSEQ);
        step(); check_val("lock_nonseq", int'(addr_in_port), 2);
        lock_op = '0;
        step(); check_val("lock_release", int'(addr_in_port), 0);
`else
        check_val("nolock_second", int'(addr_in_port), 0);
`endif
        lock_op = '0;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            HRESETn  = ($urandom_range(0, 49) != 0);
            HREADYM  = ($urandom_range(0, 3) != 0);
            req_op   = 3'($urandom_range(0, (1 << N) - 1));
            trans_op = 6'($urandom_range(0, (1 << (2*N)) - 1));
            lock_op  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
        end

        // Reset mid-burst with HREADYM low.
        HRESETn  = 1'b1;
        HREADYM  = 1'b1;
        lock_op  = '0;
        req_op   = 3'b010;
        trans_op = '0;
        set_trans(1, HTRANS_NONSEQ);
        step(); check_val("pre_reset_grant", int'(addr_in_port), 1);
        set_trans(1, HTRANS_SEQ);
        step();
        HRESETn = 1'b0;
        HREADYM = 1'b0;
        step();
        check_val("midburst_rst_no_port", int'(no_port), 1);
        check_val("midburst_rst_addr", int'(addr_in_port), 0);
        check_val("midburst_rst_data", int'(data_in_port), 0);
        HRESETn = 1'b1;
        HREADYM = 1'b1;
        req_op  = 3'b111;
        trans_op = 6'b101010;
        step(); check_val("post_rst_first", int'(addr_in_port), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
